rr_mux_arbiter: RTL and testbench

//  Round-robin arbiter that shares one NUM_BITS output bus among four requesters (A..D).

---
 rtl/rr_mux_arbiter_if.sv | 22 ++
 rtl/rr_mux_arbiter.sv | 72 +++++++
 tb/tb_rr_mux_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: shared-bus bundle between four requesters and the round-robin arbiter.
//   req   : per-requester request (bit i = requester i)
//   A..D  : requester data
//   gnt   : one-hot grant back to requesters
//   SEL   : index of the granted requester (mux select)
//   valid : bus owned this cycle
//   Saida : shared output bus
interface rr_mux_arbiter_if #(
    parameter int NUM_BITS = 4
);
    logic [3:0]          req;
    logic [NUM_BITS-1:0] A;
    logic [NUM_BITS-1:0] B;
    logic [NUM_BITS-1:0] C;
    logic [NUM_BITS-1:0] D;
    logic [3:0]          gnt;
    logic [1:0]          SEL;
    logic                valid;
    logic [NUM_BITS-1:0] Saida;
    modport master (output req, A, B, C, D, input gnt, SEL, valid, Saida);
    modport slave  (input req, A, B, C, D, output gnt, SEL, valid, Saida);
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter with bounded hold time driving a 4:1 shared-bus mux.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of rr_mux_arbiter_if (req/A..D in; gnt/SEL/valid/Saida out)
module rr_mux_arbiter #(
    parameter int NUM_BITS = 4,
    parameter int MAX_HOLD = 4
) (
    input logic             clock,
    input logic             reset,
    rr_mux_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t              state_q;
    logic [1:0]          ptr_q;
    logic [1:0]          sel_q;
    logic [3:0]          gnt_q;
    logic                valid_q;
    logic [3:0]          cnt_q;
    logic [1:0]          base_ptr;
    logic [1:0]          win;
    logic                any_req;
    logic                keep;
    // On release the holder's successor becomes top priority in the same edge,
    // so the search base is SEL+1 while granting and the stored pointer while idle.
    always_comb begin
        base_ptr = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
        any_req  = |bus.req;
        win      = base_ptr;
        for (int k = 3; k >= 0; k--)
            if (bus.req[base_ptr + 2'(k)]) win = base_ptr + 2'(k);
        keep = bus.req[sel_q] && (cnt_q < 4'(MAX_HOLD));
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'd0;
            valid_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else if (state_q == IDLE) begin
            if (any_req) begin
                state_q <= GRANT;
                gnt_q   <= 4'd1 << win;
                sel_q   <= win;
                valid_q <= 1'b1;
                cnt_q   <= 4'd1;
            end
        end else if (keep) begin
            cnt_q <= cnt_q + 4'd1;
        end else begin
            ptr_q <= sel_q + 2'd1;
            if (any_req) begin
                gnt_q <= 4'd1 << win;
                sel_q <= win;
                cnt_q <= 4'd1;
            end else begin
                state_q <= IDLE;
                gnt_q   <= 4'd0;
                valid_q <= 1'b0;
            end
        end
    end
    assign bus.gnt   = gnt_q;
    assign bus.SEL   = sel_q;
    assign bus.valid = valid_q;
    assign bus.Saida = !valid_q      ? '0    :
                       sel_q == 2'd0 ? bus.A :
                       sel_q == 2'd1 ? bus.B :
                       sel_q == 2'd2 ? bus.C : bus.D;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed self-checking bench for rr_mux_arbiter.
module tb_rr_mux_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    rr_mux_arbiter_if #(.NUM_BITS(4)) bus ();
    rr_mux_arbiter #(.NUM_BITS(4), .MAX_HOLD(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );
    always #5 clock = ~clock;
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_bus(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic [3:0] d);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".SEL"}, 32'(bus.SEL), 32'(s));
        chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
        chk({tag, ".Saida"}, 32'(bus.Saida), 32'(d));
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
    initial begin
        bus.req = 4'b0000;
        bus.A = 4'h1;
        bus.B = 4'h2;
        bus.C = 4'h3;
        bus.D = 4'h4;
        tick();
        tick();
        chk_bus("reset", 4'b0000, 2'd0, 1'b0, 4'h0);
        chk("reset.cnt", 32'(dut.cnt_q), 32'd0);
        reset = 1'b0;
        tick();
        chk_bus("idle_noreq", 4'b0000, 2'd0, 1'b0, 4'h0);
        // single requester B
        bus.req = 4'b0010;
        bus.B = 4'hA;
        tick();
        chk_bus("single.k1", 4'b0010, 2'd1, 1'b1, 4'hA);
        tick();
        tick();
        chk_bus("single.k3", 4'b0010, 2'd1, 1'b1, 4'hA);
        bus.req = 4'b0000;
        tick();
        chk_bus("single.drop", 4'b0000, 2'd1, 1'b0, 4'h0);
        bus.B = 4'h2;
        // reset mid-grant with C holding
        bus.req = 4'b0100;
        tick();
        chk_bus("pre_reset", 4'b0100, 2'd2, 1'b1, 4'h3);
        #2 reset = 1'b1;
        #1;
        chk_bus("async_reset", 4'b0000, 2'd0, 1'b0, 4'h0);
        tick();
        reset = 1'b0;
        bus.req = 4'b1001;
        tick();
        chk_bus("post_reset_ptr0", 4'b0001, 2'd0, 1'b1, 4'h1);
        bus.req = 4'b0000;
        tick();
        chk("post_reset_idle.valid", 32'(bus.valid), 32'd0);
        // full contention with data routing
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk_bus($sformatf("contend%0d", i), 4'd1 << ((i / 4) % 4), 2'((i / 4) % 4),
                    1'b1, 4'(((i / 4) % 4) + 1));
        end
        bus.req = 4'b0000;
        tick();
        chk_bus("contend.end", 4'b0000, 2'd0, 1'b0, 4'h0);
        // sole holder re-granted at the hold limit
        do_reset();
        bus.req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("sole%0d.gnt", i), 32'(bus.gnt), 32'b0001);
            chk($sformatf("sole%0d.cnt", i), 32'(dut.cnt_q), 32'((i % 4) + 1));
        end
        bus.req = 4'b0000;
        tick();
        chk("sole.end.valid", 32'(bus.valid), 32'd0);
        // handoff order: C drops with A and D requesting -> D, then A
        bus.req = 4'b0100;
        tick();
        chk_bus("hand.c", 4'b0100, 2'd2, 1'b1, 4'h3);
        bus.req = 4'b1001;
        tick();
        chk_bus("hand.d", 4'b1000, 2'd3, 1'b1, 4'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hand.dhold%0d", i), 32'(bus.gnt), 32'b1000);
        end
        tick();
        chk_bus("hand.a", 4'b0001, 2'd0, 1'b1, 4'h1);
        bus.req = 4'b0000;
        tick();
        chk_bus("hand.end", 4'b0000, 2'd0, 1'b0, 4'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
